// File: rtl/mem_noc_arbiter_2to1_if.sv
// rtl/mem_noc_arbiter_2to1_if.sv - mem_noc payload types and request/response bus interface
//
// Purpose: payload types for the mem_noc request/response channels and the
//   bus interface that carries one requester<->responder link.
// Ports (interface signals):
//   req_valid / req_ready / req      request channel, master -> slave
//   resp_valid / resp_ready / resp   response channel, slave -> master
// Modports:
//   master  drives req_valid, req, resp_ready
//   slave   drives req_ready, resp_valid, resp

package mem_noc_arb_pkg;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } mem_resp_t;
endpackage

interface mem_noc_arbiter_2to1_if;
  import mem_noc_arb_pkg::*;

  logic      req_valid;
  logic      req_ready;
  mem_req_t  req;
  logic      resp_valid;
  logic      resp_ready;
  mem_resp_t resp;

  modport master (
    output req_valid, req, resp_ready,
    input  req_ready, resp_valid, resp
  );

  modport slave (
    input  req_valid, req, resp_ready,
    output req_ready, resp_valid, resp
  );
endinterface

// File: rtl/mem_noc_arbiter_2to1.sv
// rtl/mem_noc_arbiter_2to1.sv - 2:1 mem_noc request arbiter with in-order response routing
//
// Purpose: shares one mem_noc master port between requester 0 (core data)
//   and requester 1 (debug SBA). Round-robin request arbitration, responses
//   routed back through an in-order master-ID FIFO, up to OUTST_DEPTH in flight.
//   Request and response paths are zero-cycle pass-through.
// Configuration macro: MEM_NOC_ARB_FIXED_PRIO_EN
//   defined   - m0 always wins a tie (lock still honoured), no round-robin state
//   undefined - round-robin tie break
// Ports:
//   clk   in  clock, all state on rising edge
//   rst   in  synchronous reset, active-high
//   m0    slave modport, requester 0
//   m1    slave modport, requester 1
//   sn    master modport, downstream mem_noc port

module mem_noc_arbiter_2to1 #(
  parameter  int OUTST_DEPTH = 2,
  localparam int CNT_W       = $clog2(OUTST_DEPTH + 1)
) (
  input logic                    clk,
  input logic                    rst,
  mem_noc_arbiter_2to1_if.slave  m0,
  mem_noc_arbiter_2to1_if.slave  m1,
  mem_noc_arbiter_2to1_if.master sn
);

  localparam int PTR_W = (OUTST_DEPTH > 1) ? $clog2(OUTST_DEPTH) : 1;

  logic             r_lock_vld;
  logic             r_lock_id;
  logic             r_fifo [OUTST_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_cnt;
`ifndef MEM_NOC_ARB_FIXED_PRIO_EN
  logic             r_rr_pri;
`endif

  logic w_full;
  logic w_empty;
  logic w_gnt_vld;
  logic w_gnt_id;
  logic w_req_hs;
  logic w_resp_hs;
  logic w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTST_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Full is judged on the registered count only, so a pop this cycle never
  // frees a slot for a push this cycle: no response->request comb path.
  assign w_full  = (r_cnt == CNT_W'(OUTST_DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  always_comb begin
    w_gnt_vld = r_lock_vld | m0.req_valid | m1.req_valid;
    w_gnt_id  = 1'b0;
    if (r_lock_vld) begin
      w_gnt_id = r_lock_id;
    end else if (m0.req_valid && m1.req_valid) begin
`ifdef MEM_NOC_ARB_FIXED_PRIO_EN
      w_gnt_id = 1'b0;
`else
      w_gnt_id = r_rr_pri;
`endif
    end else if (m1.req_valid) begin
      w_gnt_id = 1'b1;
    end
  end

  // Request channel
  always_comb begin
    sn.req_valid = !rst && !w_full && w_gnt_vld;
    sn.req       = w_gnt_id ? m1.req : m0.req;
    m0.req_ready = !rst && !w_full && w_gnt_vld && !w_gnt_id && sn.req_ready;
    m1.req_ready = !rst && !w_full && w_gnt_vld &&  w_gnt_id && sn.req_ready;
  end

  assign w_req_hs = sn.req_valid && sn.req_ready;

  // Response channel: only the FIFO head master sees the response; with an
  // empty FIFO a stray response is stalled rather than dropped.
  always_comb begin
    sn.resp_ready = !rst && !w_empty && (w_head ? m1.resp_ready : m0.resp_ready);
    m0.resp_valid = !rst && !w_empty && !w_head && sn.resp_valid;
    m1.resp_valid = !rst && !w_empty &&  w_head && sn.resp_valid;
    m0.resp       = (!w_empty && !w_head) ? sn.resp : '0;
    m1.resp       = (!w_empty &&  w_head) ? sn.resp : '0;
  end

  assign w_resp_hs = sn.resp_valid && sn.resp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
`ifndef MEM_NOC_ARB_FIXED_PRIO_EN
      r_rr_pri   <= 1'b0;
`endif
    end else begin
      // Hold the grant while the downstream stalls so the payload cannot
      // switch masters mid-handshake.
      if (w_req_hs) begin
        r_lock_vld <= 1'b0;
`ifndef MEM_NOC_ARB_FIXED_PRIO_EN
        r_rr_pri   <= ~w_gnt_id;
`endif
      end else if (sn.req_valid) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_gnt_id;
      end

      if (w_req_hs)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_resp_hs) r_rd_ptr <= ptr_inc(r_rd_ptr);

      case ({w_req_hs, w_resp_hs})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_req_hs) r_fifo[r_wr_ptr] <= w_gnt_id;
  end

endmodule

// File: tb/tb_mem_noc_arbiter_2to1.sv
// tb/tb_mem_noc_arbiter_2to1.sv - directed self-checking bench for mem_noc_arbiter_2to1
module tb_mem_noc_arbiter_2to1;
  import mem_noc_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  mem_noc_arbiter_2to1_if m0_if ();
  mem_noc_arbiter_2to1_if m1_if ();
  mem_noc_arbiter_2to1_if sn_if ();

  mem_noc_arbiter_2to1 #(.OUTST_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if.slave),
    .m1  (m1_if.slave),
    .sn  (sn_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_if.req_valid  = 1'b0;
    m0_if.req        = '0;
    m0_if.resp_ready = 1'b0;
    m1_if.req_valid  = 1'b0;
    m1_if.req        = '0;
    m1_if.resp_ready = 1'b0;
    sn_if.req_ready  = 1'b0;
    sn_if.resp_valid = 1'b0;
    sn_if.resp       = '0;
  endtask

  function automatic mem_req_t mk_req(input logic [31:0] a);
    mem_req_t r;
    r.we    = a[0];
    r.addr  = a;
    r.wdata = ~a;
    return r;
  endfunction

  function automatic mem_resp_t mk_resp(input logic [31:0] d);
    mem_resp_t r;
    r.err   = d[1];
    r.rdata = d;
    return r;
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    m0_if.req_valid  = 1'b1;
    sn_if.req_ready  = 1'b1;
    sn_if.resp_valid = 1'b1;
    m0_if.resp_ready = 1'b1;
    #1;
    n_total++; if (sn_if.req_valid !== 1'b0) $display("FAIL rst_sn_req_valid: got %b want 0", sn_if.req_valid); else n_pass++;
    n_total++; if (m0_if.req_ready !== 1'b0) $display("FAIL rst_m0_req_ready: got %b want 0", m0_if.req_ready); else n_pass++;
    n_total++; if (sn_if.resp_ready !== 1'b0) $display("FAIL rst_sn_resp_ready: got %b want 0", sn_if.resp_ready); else n_pass++;
    step();
    step();
    rst = 1'b0;
    idle();
    sn_if.resp_valid = 1'b1;
    m0_if.resp_ready = 1'b1;
    m1_if.resp_ready = 1'b1;
    #1;
    n_total++; if (sn_if.req_valid !== 1'b0) $display("FAIL idle_sn_req_valid: got %b want 0", sn_if.req_valid); else n_pass++;
    n_total++; if (sn_if.resp_ready !== 1'b0) $display("FAIL idle_sn_resp_ready: got %b want 0", sn_if.resp_ready); else n_pass++;
    n_total++; if (m0_if.resp_valid !== 1'b0) $display("FAIL idle_m0_resp_valid: got %b want 0", m0_if.resp_valid); else n_pass++;
    step();
    idle();
  endtask

  task automatic test_rr_basic();
    idle();
    m0_if.req_valid = 1'b1; m0_if.req = mk_req(32'h0000_1000);
    m1_if.req_valid = 1'b1; m1_if.req = mk_req(32'h0000_2000);
    sn_if.req_ready = 1'b1;
    #1;
    n_total++; if (sn_if.req_valid !== 1'b1) $display("FAIL rr_c0_valid: got %b want 1", sn_if.req_valid); else n_pass++;
    n_total++; if (sn_if.req !== mk_req(32'h0000_1000)) $display("FAIL rr_c0_req: got %h want %h", sn_if.req, mk_req(32'h0000_1000)); else n_pass++;
    n_total++; if (m0_if.req_ready !== 1'b1) $display("FAIL rr_c0_m0_ready: got %b want 1", m0_if.req_ready); else n_pass++;
    n_total++; if (m1_if.req_ready !== 1'b0) $display("FAIL rr_c0_m1_ready: got %b want 0", m1_if.req_ready); else n_pass++;
    step();
    m0_if.req_valid = 1'b0;
    #1;
    n_total++; if (sn_if.req !== mk_req(32'h0000_2000)) $display("FAIL rr_c1_req: got %h want %h", sn_if.req, mk_req(32'h0000_2000)); else n_pass++;
    n_total++; if (m1_if.req_ready !== 1'b1) $display("FAIL rr_c1_m1_ready: got %b want 1", m1_if.req_ready); else n_pass++;
    step();
    idle();
    m0_if.resp_ready = 1'b1;
    m1_if.resp_ready = 1'b1;
    sn_if.resp_valid = 1'b1;
    sn_if.resp       = mk_resp(32'hA0A0_0000);
    #1;
    n_total++; if (m0_if.resp_valid !== 1'b1) $display("FAIL rr_r0_m0_valid: got %b want 1", m0_if.resp_valid); else n_pass++;
    n_total++; if (m0_if.resp !== mk_resp(32'hA0A0_0000)) $display("FAIL rr_r0_m0_resp: got %h want %h", m0_if.resp, mk_resp(32'hA0A0_0000)); else n_pass++;
    n_total++; if (m1_if.resp_valid !== 1'b0) $display("FAIL rr_r0_m1_valid: got %b want 0", m1_if.resp_valid); else n_pass++;
    n_total++; if (m1_if.resp !== '0) $display("FAIL rr_r0_m1_resp: got %h want 0", m1_if.resp); else n_pass++;
    n_total++; if (sn_if.resp_ready !== 1'b1) $display("FAIL rr_r0_sn_ready: got %b want 1", sn_if.resp_ready); else n_pass++;
    step();
    sn_if.resp = mk_resp(32'hB1B1_0001);
    #1;
    n_total++; if (m1_if.resp_valid !== 1'b1) $display("FAIL rr_r1_m1_valid: got %b want 1", m1_if.resp_valid); else n_pass++;
    n_total++; if (m1_if.resp !== mk_resp(32'hB1B1_0001)) $display("FAIL rr_r1_m1_resp: got %h want %h", m1_if.resp, mk_resp(32'hB1B1_0001)); else n_pass++;
    n_total++; if (m0_if.resp_valid !== 1'b0) $display("FAIL rr_r1_m0_valid: got %b want 0", m0_if.resp_valid); else n_pass++;
    step();
    idle();
  endtask

  task automatic test_lock();
    idle();
    m1_if.req_valid = 1'b1; m1_if.req = mk_req(32'h0000_2100);
    #1;
    n_total++; if (sn_if.req_valid !== 1'b1) $display("FAIL lock_c0_valid: got %b want 1", sn_if.req_valid); else n_pass++;
    n_total++; if (m1_if.req_ready !== 1'b0) $display("FAIL lock_c0_m1_ready: got %b want 0", m1_if.req_ready); else n_pass++;
    step();
    m0_if.req_valid = 1'b1; m0_if.req = mk_req(32'h0000_1100);
    #1;
    n_total++; if (sn_if.req !== mk_req(32'h0000_2100)) $display("FAIL lock_c1_req: got %h want %h", sn_if.req, mk_req(32'h0000_2100)); else n_pass++;
    n_total++; if (m0_if.req_ready !== 1'b0) $display("FAIL lock_c1_m0_ready: got %b want 0", m0_if.req_ready); else n_pass++;
    step();
    #1;
    n_total++; if (sn_if.req !== mk_req(32'h0000_2100)) $display("FAIL lock_c2_req: got %h want %h", sn_if.req, mk_req(32'h0000_2100)); else n_pass++;
    step();
    sn_if.req_ready = 1'b1;
    #1;
    n_total++; if (sn_if.req !== mk_req(32'h0000_2100)) $display("FAIL lock_c3_req: got %h want %h", sn_if.req, mk_req(32'h0000_2100)); else n_pass++;
    n_total++; if (m1_if.req_ready !== 1'b1) $display("FAIL lock_c3_m1_ready: got %b want 1", m1_if.req_ready); else n_pass++;
    n_total++; if (m0_if.req_ready !== 1'b0) $display("FAIL lock_c3_m0_ready: got %b want 0", m0_if.req_ready); else n_pass++;
    step();
    m1_if.req_valid = 1'b0;
    #1;
    n_total++; if (sn_if.req !== mk_req(32'h0000_1100)) $display("FAIL lock_c4_req: got %h want %h", sn_if.req, mk_req(32'h0000_1100)); else n_pass++;
    n_total++; if (m0_if.req_ready !== 1'b1) $display("FAIL lock_c4_m0_ready: got %b want 1", m0_if.req_ready); else n_pass++;
    step();
    idle();
  endtask

  // FIFO now holds {m1, m0}: full at depth 2
  task automatic test_full();
    idle();
    m0_if.req_valid = 1'b1; m0_if.req = mk_req(32'h0000_1200);
    sn_if.req_ready = 1'b1;
    #1;
    n_total++; if (sn_if.req_valid !== 1'b0) $display("FAIL full_sn_valid: got %b want 0", sn_if.req_valid); else n_pass++;
    n_total++; if (m0_if.req_ready !== 1'b0) $display("FAIL full_m0_ready: got %b want 0", m0_if.req_ready); else n_pass++;
    step();
    sn_if.resp_valid = 1'b1;
    sn_if.resp       = mk_resp(32'hB2B2_0002);
    m0_if.resp_ready = 1'b1;
    m1_if.resp_ready = 1'b1;
    #1;
    n_total++; if (m1_if.resp_valid !== 1'b1) $display("FAIL full_pop_m1_valid: got %b want 1", m1_if.resp_valid); else n_pass++;
    n_total++; if (sn_if.resp_ready !== 1'b1) $display("FAIL full_pop_sn_ready: got %b want 1", sn_if.resp_ready); else n_pass++;
    n_total++; if (m0_if.req_ready !== 1'b0) $display("FAIL full_no_bypass: got %b want 0", m0_if.req_ready); else n_pass++;
    step();
    sn_if.resp_valid = 1'b0;
    #1;
    n_total++; if (m0_if.req_ready !== 1'b1) $display("FAIL full_after_pop_ready: got %b want 1", m0_if.req_ready); else n_pass++;
    n_total++; if (sn_if.req !== mk_req(32'h0000_1200)) $display("FAIL full_after_pop_req: got %h want %h", sn_if.req, mk_req(32'h0000_1200)); else n_pass++;
    step();
    idle();
  endtask

  // FIFO now holds {m0, m0}
  task automatic test_resp_stall();
    idle();
    sn_if.resp_valid = 1'b1;
    sn_if.resp       = mk_resp(32'hA3A3_0003);
    m1_if.resp_ready = 1'b1;
    #1;
    n_total++; if (m0_if.resp_valid !== 1'b1) $display("FAIL stall_m0_valid: got %b want 1", m0_if.resp_valid); else n_pass++;
    n_total++; if (sn_if.resp_ready !== 1'b0) $display("FAIL stall_sn_ready: got %b want 0", sn_if.resp_ready); else n_pass++;
    n_total++; if (m1_if.resp_valid !== 1'b0) $display("FAIL stall_m1_valid: got %b want 0", m1_if.resp_valid); else n_pass++;
    step();
    step();
    n_total++; if (m0_if.resp !== mk_resp(32'hA3A3_0003)) $display("FAIL stall_hold_resp: got %h want %h", m0_if.resp, mk_resp(32'hA3A3_0003)); else n_pass++;
    n_total++; if (sn_if.resp_ready !== 1'b0) $display("FAIL stall_hold_ready: got %b want 0", sn_if.resp_ready); else n_pass++;
    m0_if.resp_ready = 1'b1;
    #1;
    n_total++; if (sn_if.resp_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", sn_if.resp_ready); else n_pass++;
    step();
    sn_if.resp = mk_resp(32'hA4A4_0004);
    #1;
    n_total++; if (m0_if.resp_valid !== 1'b1) $display("FAIL stall_second_valid: got %b want 1", m0_if.resp_valid); else n_pass++;
    n_total++; if (m0_if.resp !== mk_resp(32'hA4A4_0004)) $display("FAIL stall_second_resp: got %h want %h", m0_if.resp, mk_resp(32'hA4A4_0004)); else n_pass++;
    step();
    #1;
    n_total++; if (sn_if.resp_ready !== 1'b0) $display("FAIL stray_sn_ready: got %b want 0", sn_if.resp_ready); else n_pass++;
    n_total++; if (m0_if.resp_valid !== 1'b0) $display("FAIL stray_m0_valid: got %b want 0", m0_if.resp_valid); else n_pass++;
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    m1_if.req_valid = 1'b1; m1_if.req = mk_req(32'h0000_2300);
    sn_if.req_ready = 1'b1;
    #1;
    n_total++; if (m1_if.req_ready !== 1'b1) $display("FAIL rmid_m1_ready: got %b want 1", m1_if.req_ready); else n_pass++;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sn_if.resp_valid = 1'b1;
    m1_if.resp_ready = 1'b1;
    #1;
    n_total++; if (sn_if.resp_ready !== 1'b0) $display("FAIL rmid_sn_ready: got %b want 0", sn_if.resp_ready); else n_pass++;
    n_total++; if (m1_if.resp_valid !== 1'b0) $display("FAIL rmid_m1_valid: got %b want 0", m1_if.resp_valid); else n_pass++;
    step();
    idle();
  endtask

  // Both requesters valid every cycle; each accepted request answered the next cycle
  task automatic test_back_to_back();
    logic        exp_g [4];
    logic        prev_g;
    logic        obs;
    logic [31:0] exp_addr;
`ifdef MEM_NOC_ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    idle();
    prev_g = 1'b0;
    m0_if.resp_ready = 1'b1;
    m1_if.resp_ready = 1'b1;
    sn_if.req_ready  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      m0_if.req_valid  = (k < 4);
      m1_if.req_valid  = (k < 4);
      m0_if.req        = mk_req(32'h0000_0100 + k);
      m1_if.req        = mk_req(32'h0000_0200 + k);
      sn_if.resp_valid = (k > 0);
      sn_if.resp       = mk_resp(32'hC000_0000 + k);
      #1;
      if (k < 4) begin
        exp_addr = exp_g[k] ? 32'h0000_0200 + k : 32'h0000_0100 + k;
        n_total++; if (sn_if.req.addr !== exp_addr) $display("FAIL b2b_req_addr k=%0d: got %h want %h", k, sn_if.req.addr, exp_addr); else n_pass++;
        n_total++; if (m0_if.req_ready !== !exp_g[k]) $display("FAIL b2b_m0_ready k=%0d: got %b want %b", k, m0_if.req_ready, !exp_g[k]); else n_pass++;
        n_total++; if (m1_if.req_ready !== exp_g[k]) $display("FAIL b2b_m1_ready k=%0d: got %b want %b", k, m1_if.req_ready, exp_g[k]); else n_pass++;
      end
      if (k > 0) begin
        obs = prev_g ? m1_if.resp_valid : m0_if.resp_valid;
        n_total++; if (obs !== 1'b1) $display("FAIL b2b_resp_route k=%0d: got %b want 1 at master %0d", k, obs, prev_g); else n_pass++;
        obs = prev_g ? m0_if.resp_valid : m1_if.resp_valid;
        n_total++; if (obs !== 1'b0) $display("FAIL b2b_resp_other k=%0d: got %b want 0", k, obs); else n_pass++;
      end
      if (k < 4) prev_g = exp_g[k];
      step();
    end
    idle();
    sn_if.resp_valid = 1'b1;
    #1;
    n_total++; if (sn_if.resp_ready !== 1'b0) $display("FAIL b2b_drained: got %b want 0", sn_if.resp_ready); else n_pass++;
    step();
    idle();
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    idle();
    test_reset();
    test_rr_basic();
    test_lock();
    test_full();
    test_resp_stall();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
